// File: rtl/seq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_divider : sequential restoring divider, one quotient bit per clock.   |
// | Optional macro SIGNED_DIV_EN selects two's-complement operands.           |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0]       S_IDLE      = 2'd0;
    localparam logic [1:0]       S_RUN       = 2'd1;
    localparam logic [1:0]       S_DONE      = 2'd2;
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_dvs_zero;
    logic             w_last;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_q_final;
    logic [WIDTH-1:0] w_r_final;

    assign w_dvs_zero = (divisor == '0);
    assign w_last     = (r_cnt == c_last_iter);

    // Full R is kept in the trial value so a divisor with its MSB set still compares correctly.
    assign w_trial  = {r_r, r_q[WIDTH-1]};
    assign w_diff   = w_trial - {1'b0, r_d};
    assign w_fits   = ~w_diff[WIDTH];
    assign w_r_next = w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_q_next = {r_q[WIDTH-2:0], w_fits};

`ifdef SIGNED_DIV_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_dvd_neg;
    logic w_dvs_neg;

    assign w_dvd_neg = dividend[WIDTH-1];
    assign w_dvs_neg = divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;
    assign w_q_final = r_neg_q ? (~w_q_next + 1'b1) : w_q_next;
    assign w_r_final = r_neg_r ? (~w_r_next + 1'b1) : w_r_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
    assign w_q_final = w_q_next;
    assign w_r_final = w_r_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_dvs_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_d         <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q   <= w_dvd_mag;
                        r_d   <= w_dvs_mag;
                        r_r   <= '0;
                        r_cnt <= '0;
                        r_dbz <= 1'b0;
                        // Zero divisor skips iteration; remainder reports the untouched operand.
                        if (w_dvs_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt + c_cnt_one;
                    if (w_last) begin
                        r_quotient  <= w_q_final;
                        r_remainder <= w_r_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
